// File: rtl/data_mem_ws.sv
// data_mem_ws: wait-state single-port data RAM with byte enables.
// Optional: DATA_MEM_RANGE_CHK_EN flags out-of-range word addresses.
module data_mem_ws #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [15:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ack,
  output logic                    err,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [15:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    oor;
  logic                    fire;

  assign idx  = addr_q[ADDR_WIDTH-1:0];
  assign fire = (state == WAIT) && (cnt == 4'd0);

`ifdef DATA_MEM_RANGE_CHK_EN
  assign oor = (addr_q >> ADDR_WIDTH) != 16'd0;
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = ^(addr_q >> ADDR_WIDTH);
`endif

  // Handshake FSM; captures the request and commits reads/err at the access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          ack <= 1'b0;
          if (req) begin
            state   <= WAIT;
            busy    <= 1'b1;
            cnt     <= 4'(WAIT_STATES);
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            ack   <= 1'b1;
            err   <= oor;
            if (!we_q)
              rdata <= oor ? '0 : mem[idx];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port; only enabled bytes of an in-range word change.
  always_ff @(posedge clk) begin
    if (fire && we_q && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: two instances (2 and 0 wait states) against a
// timestamp-based transaction model, plus pinned directed checks.
module tb_data_mem_ws;

  localparam int WS0 = 2;
  localparam int WS1 = 0;
`ifdef DATA_MEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdata = 16'd0;
  logic [1:0]  be = 2'd0;
  logic [15:0] rd0, rd1;
  logic        ack0, ack1, err0, err1, busy0, busy1;

  always #5 clk = ~clk;

  data_mem_ws #(.WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rd0), .ack(ack0), .err(err0),
    .busy(busy0)
  );

  data_mem_ws #(.WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rd1), .ack(ack1), .err(err1),
    .busy(busy1)
  );

  int total = 0;
  int bad = 0;
  int k = 0;

  logic [15:0] mm [2][256];
  bit          kn [2][256];
  bit          pend [2];
  int          due [2];
  bit          m_ack [2];
  bit          m_err [2];
  logic [15:0] m_rd [2];
  bit          rk [2];
  bit          t_we [2];
  logic [15:0] t_addr [2];
  logic [15:0] t_wd [2];
  logic [1:0]  t_be [2];

  function automatic bit oor_f(logic [15:0] a);
    return CHK && (a[15:8] != 8'd0);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mres();
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0;
      m_ack[d] = 1'b0;
      m_err[d] = 1'b0;
      m_rd[d] = 16'd0;
      rk[d] = 1'b1;
    end
  endtask

  // One edge of the transaction model: access due now, else maybe accept.
  task automatic step(int d, int ws);
    int ix;
    m_ack[d] = 1'b0;
    if (pend[d]) begin
      if (due[d] == k) begin
        pend[d] = 1'b0;
        m_ack[d] = 1'b1;
        m_err[d] = oor_f(t_addr[d]);
        ix = int'(t_addr[d][7:0]);
        if (t_we[d]) begin
          if (!m_err[d]) begin
            for (int b = 0; b < 2; b++)
              if (t_be[d][b]) mm[d][ix][8*b +: 8] = t_wd[d][8*b +: 8];
            if (t_be[d] == 2'b11) kn[d][ix] = 1'b1;
          end
        end else begin
          m_rd[d] = m_err[d] ? 16'd0 : mm[d][ix];
          rk[d] = m_err[d] || kn[d][ix];
        end
      end
    end else if (req) begin
      pend[d] = 1'b1;
      due[d] = k + ws + 1;
      t_we[d] = we;
      t_addr[d] = addr;
      t_wd[d] = wdata;
      t_be[d] = be;
    end
  endtask

  task automatic cmp_all();
    chk("busy0", busy0, pend[0]);
    chk("ack0", ack0, m_ack[0]);
    chk("busy1", busy1, pend[1]);
    chk("ack1", ack1, m_ack[1]);
    if (m_ack[0]) chk("err0", err0, m_err[0]);
    if (m_ack[1]) chk("err1", err1, m_err[1]);
    if (rk[0]) chk("rdata0", rd0, m_rd[0]);
    if (rk[1]) chk("rdata1", rd1, m_rd[1]);
  endtask

  task automatic cyc(bit r, bit w, logic [15:0] a, logic [15:0] wd,
                     logic [1:0] b);
    req = r;
    we = w;
    addr = a;
    wdata = wd;
    be = b;
    @(posedge clk);
    k++;
    step(0, WS0);
    step(1, WS1);
    @(negedge clk);
    cmp_all();
  endtask

  // Issue one request and idle until both instances have completed it.
  task automatic txn(bit w, logic [15:0] a, logic [15:0] wd, logic [1:0] b,
                     output int lat, output int nb, output bit e);
    int n;
    n = 0;
    lat = -1;
    nb = 0;
    e = 1'b0;
    cyc(1'b1, w, a, wd, b);
    nb += int'(busy0);
    for (int i = 0; i < 40 && (pend[0] || pend[1]); i++) begin
      cyc(1'b0, 1'b0, 16'd0, 16'd0, 2'd0);
      n++;
      nb += int'(busy0);
      if (ack0 && lat < 0) begin
        lat = n;
        e = err0;
      end
    end
  endtask

  initial begin
    int lat, nb, acks;
    bit e;
    logic [15:0] a;
    mres();
    repeat (2) @(negedge clk);
    cmp_all();
    chk("rst_rdata0", rd0, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      txn(1'b1, 16'(i), 16'($urandom), 2'b11, lat, nb, e);

    txn(1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, nb, e);
    chk("wr_lat", lat, 3);
    chk("wr_busy", nb, 3);
    txn(1'b0, 16'h0010, 16'h0000, 2'b11, lat, nb, e);
    chk("rd_lat", lat, 3);
    chk("rd_busy", nb, 3);
    chk("rd_beef0", rd0, 16'hBEEF);
    chk("rd_beef1", rd1, 16'hBEEF);

    txn(1'b1, 16'h0003, 16'h1234, 2'b11, lat, nb, e);
    txn(1'b1, 16'h0003, 16'hABCD, 2'b01, lat, nb, e);
    txn(1'b0, 16'h0003, 16'h0000, 2'b00, lat, nb, e);
    chk("be_0", rd0, 16'h12CD);
    chk("be_1", rd1, 16'h12CD);

    acks = 0;
    cyc(1'b1, 1'b1, 16'h0001, 16'hA1A1, 2'b11);
    acks += int'(ack1);
    cyc(1'b1, 1'b0, 16'h0001, 16'hDEAD, 2'b11);
    acks += int'(ack1);
    cyc(1'b1, 1'b0, 16'h0001, 16'h0000, 2'b11);
    acks += int'(ack1);
    cyc(1'b1, 1'b1, 16'h0001, 16'hDEAD, 2'b11);
    acks += int'(ack1);
    chk("b2b_rd", rd1, 16'hA1A1);
    cyc(1'b1, 1'b1, 16'h0001, 16'hB2B2, 2'b11);
    acks += int'(ack1);
    cyc(1'b1, 1'b0, 16'h0001, 16'h0000, 2'b11);
    acks += int'(ack1);
    chk("b2b_acks", acks, 3);
    for (int i = 0; i < 20 && (pend[0] || pend[1]); i++)
      cyc(1'b0, 1'b0, 16'd0, 16'd0, 2'd0);

    txn(1'b1, 16'h0007, 16'h7777, 2'b11, lat, nb, e);
    chk("rng_err_ok", e, 1'b0);
    txn(1'b1, 16'h0107, 16'h5555, 2'b11, lat, nb, e);
    chk("rng_err_wr", e, CHK);
    txn(1'b0, 16'h0107, 16'h0000, 2'b11, lat, nb, e);
    chk("rng_err_rd", e, CHK);
    chk("rng_rd_hi", rd0, CHK ? 16'h0000 : 16'h5555);
    txn(1'b0, 16'h0007, 16'h0000, 2'b11, lat, nb, e);
    chk("rng_rd_lo", rd0, CHK ? 16'h7777 : 16'h5555);

    txn(1'b1, 16'h0005, 16'h0A0A, 2'b11, lat, nb, e);
    cyc(1'b1, 1'b1, 16'h0005, 16'hFFFF, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out0", {rd0, ack0, err0, busy0}, 19'd0);
    chk("arst_out1", {rd1, ack1, err1, busy1}, 19'd0);
    mres();
    #1 rst_n = 1'b1;
    txn(1'b0, 16'h0005, 16'h0000, 2'b11, lat, nb, e);
    chk("arst_keep0", rd0, 16'h0A0A);
    chk("arst_keep1", rd1, 16'h0A0A);

    for (int i = 0; i < 600; i++) begin
      a = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | 16'h0100;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
          16'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised, wait-state data memory for the mips_16 core's memory stage and its planned external-memory path. It is a single-port RAM with configurable word width and depth, and per-byte write enables. A req/ack handshake with a programmable access latency lets the pipeline exercise a stall path. Reads are registered and held until the next completed read.

## Interface
- `DATA_WIDTH`, 16: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 8: implemented word-address bits; depth is 2**ADDR_WIDTH words.
- `WAIT_STATES`, 2: extra cycles per access, 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  1  access request; sampled only when not busy.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  16  word address; sampled with `req`.
- `wdata`  in  DATA_WIDTH  write data; sampled with `req`.
- `be`  in  DATA_WIDTH/8  byte enables for writes; bit i enables byte i; ignored on reads.
- `rdata`  out  DATA_WIDTH  registered read data.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  error flag, valid only while `ack` = 1.
- `busy`  out  1  transaction in flight; `req` is ignored while busy.

## Operation
- **States:**
  - IDLE: nothing in flight.
  - WAIT: transaction in flight; holds a down-counter `cnt` of 4 bits.
  - DONE: one cycle with `ack` = 1.
- **IDLE or DONE with `req` = 1:**
  - Capture `we`, `addr`, `wdata` and `be`.
  - Load `cnt` = WAIT_STATES.
  - Go to WAIT.
- **IDLE or DONE with `req` = 0:** go to or stay in IDLE.
- **WAIT with `cnt` ≠ 0:** decrement `cnt`.
- **WAIT with `cnt` = 0:** perform the access at this edge and go to DONE.
  - Write: for each byte i with `be[i]` = 1, update that byte of the addressed word. Bytes with `be[i]` = 0 keep their value. `be` = 0 gives a no-op write that still completes and acks. `rdata` is unchanged.
  - Read: load `rdata` with the addressed word.
- **Outputs:**
  - `busy` = (state == WAIT).
  - `ack` = (state == DONE).
  - `err` is registered and loaded in the same edge as the access.
- `req` arriving while in WAIT is dropped, not queued.
- RAM contents are not reset; their power-up value is undefined.

## Timing
- Reset values: `rdata` = 0, `ack` = 0, `err` = 0, `busy` = 0, state = IDLE, `cnt` = 0.
- **Latency:**
  - `req` is sampled at edge E.
  - The memory is updated or read at edge E+WAIT_STATES+1.
  - `ack` is high for exactly the cycle following that edge.
  - WAIT_STATES = 0 gives `ack` one cycle after the request edge.
- **Throughput:** one transaction per WAIT_STATES+2 cycles, because a new `req` is accepted during the `ack` (DONE) cycle. `ack` stays a pulse per transaction and never stays high across two transactions; it drops for at least the WAIT cycles in between.
- Read after write to the same address: the read issued in the write's DONE cycle returns the new data.
- `rdata` holds its last read value through writes, idle cycles and errors. The exception is an error read, which loads 0.
- **Reset mid-operation:** `rst_n` low aborts immediately.
  - An uncommitted write leaves the RAM unchanged.
  - Outputs take their reset values asynchronously.

## Configuration
- `DATA_MEM_RANGE_CHK_EN` defined:
  - An access with `addr[15:ADDR_WIDTH]` ≠ 0 is out of range.
  - An out-of-range write does not modify the RAM.
  - An out-of-range read loads `rdata` = 0.
  - Both complete normally with `err` = 1 during `ack`.
- `DATA_MEM_RANGE_CHK_EN` undefined:
  - The address is truncated to `addr[ADDR_WIDTH-1:0]`; upper addresses alias.
  - `err` is tied to 0.
- Handshake timing is identical in both builds.

## Test plan
- **Reset:** WAIT_STATES = 2, assert `rst_n` = 0 mid-write at `addr` 0x0005 -> all outputs 0 asynchronously; a later read of 0x0005 returns its pre-write value.
- **Latency:** WAIT_STATES = 2, write 0xBEEF to 0x0010 with `be` = 2'b11, then read 0x0010 -> `busy` high 3 cycles and `ack` on the 3rd cycle after each `req` edge; `rdata` = 0xBEEF.
- **Byte enables:** write 0x1234 to 0x0003 with `be` = 2'b11, then 0xABCD with `be` = 2'b01, then read -> `rdata` = 0x12CD.
- **Back-to-back:** WAIT_STATES = 0, `req` held high for 6 cycles alternating write/read to 0x0001 -> `ack` every 2nd cycle; each read returns the preceding write's data; `req` during `busy` is dropped.
- **Range check:** `DATA_MEM_RANGE_CHK_EN` defined, ADDR_WIDTH = 8, write 0x5555 to 0x0107, then read 0x0107 and 0x0007 -> both 0x0107 accesses get `err` = 1 with `ack`, and the read returns 0; 0x0007 is unchanged.
- **Aliasing:** `DATA_MEM_RANGE_CHK_EN` undefined, same sequence -> `err` = 0 throughout; the read of 0x0007 returns 0x5555.
